ysyx_22041412_ifu: RTL and testbench

YSYX_22041412_IFU -- requirements
Module: ysyx_22041412_ifu

---
 rtl/ysyx_22041412_ifu_if.sv | 34 +++
 rtl/ysyx_22041412_ifu.sv | 89 ++++++++
 tb/tb_ysyx_22041412_ifu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041412_ifu_if.sv
// rtl/ysyx_22041412_ifu_if.sv - fetch unit bus bundle: redirects, imem request/response, decode output
interface ysyx_22041412_ifu_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        jal_ok;
  logic [63:0] jal_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  // fetch unit side
  modport master (
    input  redirect_valid, redirect_pc, jal_ok, jal_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  // pipeline / memory side
  modport slave (
    output redirect_valid, redirect_pc, jal_ok, jal_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );
endinterface

// File: rtl/ysyx_22041412_ifu.sv
// rtl/ysyx_22041412_ifu.sv - single-outstanding instruction fetch unit with redirect handling
module ysyx_22041412_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_22041412_ifu_if.master   bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] out_instr_q, out_instr_next;
  logic [31:0] out_pc_q, out_pc_next;
  logic        redirect;
  logic [31:0] target;
  logic        jal_pc_hi_unused;

  // only the low word of the decode-stage jal target is meaningful
  assign jal_pc_hi_unused = ^bus.jal_pc[63:32];

  // execute-stage redirect wins over decode-stage jal; targets are word aligned
  assign redirect = bus.redirect_valid | bus.jal_ok;
  assign target   = (bus.redirect_valid ? bus.redirect_pc : bus.jal_pc[31:0]) & 32'hFFFF_FFFC;

  // outputs are forced low while reset is held, even before the first edge
  assign bus.imem_req_valid = (state == S_REQ) && !rst;
  assign bus.imem_req_addr  = pc;
  assign bus.out_valid      = (state == S_OUT) && !rst;
  assign bus.out_instr      = out_instr_q;
  assign bus.out_pc         = out_pc_q;

  // state, pc and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      out_instr_q <= 32'h0;
      out_pc_q    <= 32'h0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      out_instr_q <= out_instr_next;
      out_pc_q    <= out_pc_next;
    end
  end

  // next-state logic; a redirect squashes whatever fetch is in flight
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    out_instr_next = out_instr_q;
    out_pc_next    = out_pc_q;
    case (state)
      S_REQ: begin
        if (bus.imem_req_ready) state_next = redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (redirect) begin
            state_next = S_REQ;
          end else begin
            state_next     = S_OUT;
            out_instr_next = bus.imem_rsp_data;
            out_pc_next    = pc;
            pc_next        = pc + 32'd4;
          end
        end else if (redirect) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.imem_rsp_valid) state_next = S_REQ;
      end
      S_OUT: begin
        if (redirect || bus.out_ready) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
    if (redirect) pc_next = target;
  end

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// tb/tb_ysyx_22041412_ifu.sv - self-checking bench for ysyx_22041412_ifu
module tb_ysyx_22041412_ifu;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ysyx_22041412_ifu_if bus();

  ysyx_22041412_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // transaction-level reference: what the fetcher currently owes the world
  bit          m_need_req;   // an address is waiting to be sent
  bit          m_inflight;   // a request was accepted, its response not yet seen
  bit          m_discard;    // the in-flight response must be thrown away
  bit          m_hold;       // an instruction is being offered to decode
  logic [31:0] m_pc, m_instr, m_opc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_update();
    logic        redir;
    logic [31:0] tgt;
    if (rst) begin
      m_need_req = 1'b1; m_inflight = 1'b0; m_discard = 1'b0; m_hold = 1'b0;
      m_pc = RESET_PC; m_instr = 32'h0; m_opc = 32'h0;
      return;
    end
    redir = bus.redirect_valid | bus.jal_ok;
    tgt   = bus.redirect_valid ? bus.redirect_pc : bus.jal_pc[31:0];
    tgt[1:0] = 2'b00;
    if (m_need_req) begin
      if (bus.imem_req_ready) begin
        m_need_req = 1'b0; m_inflight = 1'b1; m_discard = redir;
      end
    end else if (m_inflight) begin
      if (bus.imem_rsp_valid) begin
        m_inflight = 1'b0;
        if (m_discard || redir) begin
          m_need_req = 1'b1;
        end else begin
          m_hold = 1'b1; m_instr = bus.imem_rsp_data; m_opc = m_pc; m_pc = m_pc + 32'd4;
        end
      end else if (redir) begin
        m_discard = 1'b1;
      end
    end else if (m_hold) begin
      if (redir || bus.out_ready) begin
        m_hold = 1'b0; m_need_req = 1'b1;
      end
    end
    if (redir) m_pc = tgt;
  endfunction

  task automatic compare();
    check("req_valid", bus.imem_req_valid, m_need_req && !rst);
    if (m_need_req && !rst) check("req_addr", bus.imem_req_addr, m_pc);
    check("out_valid", bus.out_valid, m_hold && !rst);
    check("out_instr", bus.out_instr, m_instr);
    check("out_pc", bus.out_pc, m_opc);
  endtask

  task automatic drive(input bit r, input bit rdy, input bit rv, input logic [31:0] rd,
                       input bit redv, input logic [31:0] rpc, input bit jok,
                       input logic [63:0] jpc, input bit ordy);
    rst                = r;
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    bus.redirect_valid = redv;
    bus.redirect_pc    = rpc;
    bus.jal_ok         = jok;
    bus.jal_pc         = jpc;
    bus.out_ready      = ordy;
    #2;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    logic [31:0] a;
    // reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, RESET_PC});
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out", {bus.out_instr, bus.out_pc}, 64'h0);

    // back-to-back fetch, memory returns address as data
    for (int k = 0; k < 9; k++) begin
      a = RESET_PC + 32'(4 * (k / 3));
      drive(0, 1, 1, a, 0, 0, 0, 0, 1);
      if (k % 3 == 0) check("seq_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, a});
      if (k % 3 == 2) check("seq_out", {bus.out_valid, bus.out_pc, bus.out_instr}, {1'b1, a, a});
      if (k % 3 != 2) check("seq_out_idle", bus.out_valid, 1'b0);
      tick();
    end

    // decode stall holds output stable
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 32'h1234_ABCD, 0, 0, 0, 0, 0); tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("stall_out", {bus.out_valid, bus.imem_req_valid, bus.out_pc, bus.out_instr},
            {1'b1, 1'b0, 32'h8000_000C, 32'h1234_ABCD});
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("stall_next_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h8000_0010});
    tick();

    // jal during wait, response two cycles later is dropped
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_8000_0103, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("drop_quiet", {bus.imem_req_valid, bus.out_valid}, 2'b00);
    tick();
    drive(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("jal_req", {bus.imem_req_valid, bus.out_valid, bus.imem_req_addr}, {2'b10, 32'h8000_0100});
    tick();

    // execute redirect beats jal in the same cycle
    drive(0, 0, 0, 0, 1, 32'h8000_0200, 1, 64'h8000_0300, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("prio_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h8000_0200});
    tick();

    // pc wraps past the top of the address space
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_req", bus.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 1, 32'h0000_0013, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("wrap_out", {bus.out_valid, bus.out_pc}, {1'b1, 32'hFFFF_FFFC});
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_next", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h0});
    tick();

    // reset while waiting; the stale response is ignored
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_mid", {bus.imem_req_valid, bus.out_valid}, 2'b00);
    tick();
    drive(0, 0, 1, 32'h5555_5555, 0, 0, 0, 0, 1);
    check("stale_req", {bus.imem_req_valid, bus.out_valid, bus.imem_req_addr}, {2'b10, RESET_PC});
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("stale_ign", {bus.imem_req_valid, bus.out_valid, bus.imem_req_addr}, {2'b10, RESET_PC});
    tick();

    // random traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom, $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 7) == 0,
            {$urandom, $urandom}, $urandom_range(0, 1) == 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
